buzzer_sched: RTL and testbench
===============================

Name: buzzer_sched

Overview:
- Sequencer and arbiter for the single board buzzer.
- Shares the buzzer between 4 event sources: btn_cancel, btn_select, alert, alarm.
- Each source requests a fixed tone (square-wave half-period) for a fixed duration. Requests are latched, played one at a time in priority order, and separated by a silent gap.
- Sits between the button/event logic and the buzzer pin. Replaces the per-button tone modules.

Parameters:
- TICK_DIV, 50_000, clk cycles per duration tick (1 ms at 50 MHz).
- GAP_TICKS, 20, silent ticks between consecutive tones.
- HP0, 35_793, half-period in clk cycles, source 0 (~698 Hz).
- HP1, 47_778, half-period, source 1 (~523 Hz).
- HP2, 31_888, half-period, source 2 (~784 Hz).
- HP3, 63_776, half-period, source 3 (~392 Hz).
- DUR0 / DUR1 / DUR2 / DUR3, 100 / 100 / 200 / 500, tone length in ticks per source.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  level requests, one bit per source; index 0 = highest priority.
- mute  in  1  forces buzzer low; sequencing continues unchanged.
- buzzer  out  1  square-wave drive to the buzzer pin.
- busy  out  1  high in PLAY or GAP.
- active_id  out  2  source being played; holds its last value otherwise.
- done  out  1  one-cycle pulse on the last PLAY cycle.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; pending, all counters, edge registers, buzzer, busy, active_id and done all clear to 0.
  - Reset mid-tone silences the buzzer in the same cycle and discards all pending requests.
- Edge detect:
  - req is registered once.
  - A rising edge of req[i] sets pending[i] on the next clk.
  - A held-high req generates one request only.
  - A rising edge on a source that is already pending is absorbed: no duplicate.
- States: IDLE, PLAY, GAP.
- IDLE -> PLAY:
  - When any pending bit is set, grant the lowest index.
  - Load active_id, clear that pending bit, reset the tone, tick and duration counters.
  - Transition takes 1 cycle.
- PLAY:
  - Tone counter counts 0..HP[id]-1; buzzer toggles at wrap.
  - Buzzer starts 0 at grant, so the first rising edge comes HP cycles after entry.
  - Tick counter counts 0..TICK_DIV-1; each wrap decrements the remaining duration.
  - PLAY lasts exactly DUR[id]*TICK_DIV cycles.
  - On the last cycle: done=1. Next cycle: buzzer=0, enter GAP.
- GAP:
  - buzzer=0 for GAP_TICKS*TICK_DIV cycles.
  - Then go to PLAY if any pending bit is set (same grant rule), else IDLE.
- No preemption: a higher-priority request arriving during PLAY waits for the current tone plus the gap.
- A new edge from the currently playing source during its own PLAY sets pending; the tone replays after the gap.
- Simultaneous edges on several sources: all are latched; play order is index order.
- mute: buzzer output = internal_tone & ~mute. Timing, done and busy are unaffected.
- busy = (state != IDLE). done is 0 outside the PLAY->GAP boundary.
- Widths:
  - Tone counter: 16 bits (max HP 65_535).
  - Tick counter: clog2(TICK_DIV) bits.
  - Duration counter: 10 bits (max 1023 ticks).
  - Parameters outside these ranges are illegal.

Decomposition:
- Package buzzer_pkg holds:
  - state encoding (IDLE=0, PLAY=1, GAP=2);
  - default HP/DUR/GAP constants and TICK_DIV;
  - the source index constants (SRC_CANCEL=0, SRC_SELECT=1, SRC_ALERT=2, SRC_ALARM=3).
- Sub-module tone_gen:
  - Inputs: clk, rst, en, half_period[15:0]. Output: wave.
  - Counter plus toggle; cleared whenever en=0.
  - buzzer_sched owns arbitration, duration and gap timing.

Test Plan:
(Bench uses TICK_DIV=10, HP0..3=3/4/5/6, DUR0..3=2/3/4/5, GAP_TICKS=1.)
- Single request, pulse req[0] for 1 cycle -> busy rises 2 cycles later; buzzer toggles every 3 cycles for 20 cycles; done pulses once; buzzer 0 for 10 gap cycles; back to IDLE.
- Simultaneous req=4'b1010 -> source 1 plays (30 cycles, period 8), gap 10, source 3 plays (50 cycles, period 12); active_id goes 1 then 3.
- req[0] rises while source 3 is playing -> source 3 completes all 50 cycles; source 0 starts only after the gap.
- req[2] held high for 200 cycles -> exactly one 40-cycle tone, one done pulse.
- mute=1 during playback -> buzzer stays 0; done/busy timing identical to the unmuted run.
- rst asserted mid-PLAY with pending=4'b0100 -> buzzer, busy, pending go 0 without a clk edge; after release, no tone plays.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared constants and types for the buzzer sequencer: state encoding,
// default tone/duration table, source indices and the priority helper.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV  = 50_000;
  localparam int DEF_GAP_TICKS = 20;

  localparam int DEF_HP0 = 35_793;
  localparam int DEF_HP1 = 47_778;
  localparam int DEF_HP2 = 31_888;
  localparam int DEF_HP3 = 63_776;

  localparam int DEF_DUR0 = 100;
  localparam int DEF_DUR1 = 100;
  localparam int DEF_DUR2 = 200;
  localparam int DEF_DUR3 = 500;

  localparam logic [1:0] SRC_CANCEL = 2'd0;
  localparam logic [1:0] SRC_SELECT = 2'd1;
  localparam logic [1:0] SRC_ALERT  = 2'd2;
  localparam logic [1:0] SRC_ALARM  = 2'd3;

  // Lowest set index wins; result is meaningless when v == 0.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = SRC_ALARM;
    if (v[2]) idx = SRC_ALERT;
    if (v[1]) idx = SRC_SELECT;
    if (v[0]) idx = SRC_CANCEL;
    return idx;
  endfunction

endpackage

// File: rtl/buzzer_sched_tone_gen.sv
// Square-wave generator: wave toggles every half_period enabled cycles and
// is held cleared (counter and output) whenever en is low.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] half_period,
  output logic        wave
);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 16'd0;
      wave <= 1'b0;
    end else if (!en) begin
      cnt  <= 16'd0;
      wave <= 1'b0;
    end else if (cnt == half_period - 16'd1) begin
      cnt  <= 16'd0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer arbiter: latches rising edges of four request lines and plays one
// fixed-length tone at a time in index order, with a silent gap between tones.
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int HP0       = DEF_HP0,
  parameter int HP1       = DEF_HP1,
  parameter int HP2       = DEF_HP2,
  parameter int HP3       = DEF_HP3,
  parameter int DUR0      = DEF_DUR0,
  parameter int DUR1      = DEF_DUR1,
  parameter int DUR2      = DEF_DUR2,
  parameter int DUR3      = DEF_DUR3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t      state, state_nx;
  logic [3:0]  req_q;
  logic [3:0]  pending;
  logic [3:0]  rise;
  logic [3:0]  grant_mask;
  logic [1:0]  grant_id;
  logic        grant;
  logic        done_c;
  logic [TW-1:0] tick_cnt;
  logic [9:0]  dur_left;
  logic        tick_wrap;
  logic        phase_end;
  logic [15:0] half_period;
  logic        wave;

  function automatic logic [15:0] hp_of(input logic [1:0] id);
    case (id)
      2'd0:    return 16'(HP0);
      2'd1:    return 16'(HP1);
      2'd2:    return 16'(HP2);
      default: return 16'(HP3);
    endcase
  endfunction

  function automatic logic [9:0] dur_of(input logic [1:0] id);
    case (id)
      2'd0:    return 10'(DUR0);
      2'd1:    return 10'(DUR1);
      2'd2:    return 10'(DUR2);
      default: return 10'(DUR3);
    endcase
  endfunction

  assign rise       = req & ~req_q;
  assign grant_id   = first_set(pending);
  assign grant_mask = grant ? (4'b0001 << grant_id) : 4'b0000;
  assign tick_wrap  = (tick_cnt == TICK_LAST);
  // dur_left counts remaining ticks in the current PLAY or GAP phase.
  assign phase_end  = tick_wrap && (dur_left == 10'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant    = 1'b1;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (phase_end) begin
          done_c   = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (phase_end) begin
          if (|pending) begin
            grant    = 1'b1;
            state_nx = PLAY;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= 4'd0;
      pending   <= 4'd0;
      active_id <= 2'd0;
      tick_cnt  <= '0;
      dur_left  <= 10'd0;
    end else begin
      req_q   <= req;
      // A new edge on the source being granted this cycle re-arms it.
      pending <= (pending & ~grant_mask) | rise;
      if (grant) begin
        active_id <= grant_id;
        tick_cnt  <= '0;
        dur_left  <= dur_of(grant_id);
      end else if (state == PLAY && phase_end) begin
        tick_cnt <= '0;
        dur_left <= 10'(GAP_TICKS);
      end else if (state != IDLE) begin
        if (tick_wrap) begin
          tick_cnt <= '0;
          dur_left <= dur_left - 10'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  assign half_period = hp_of(active_id);

  tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (state == PLAY),
    .half_period (half_period),
    .wave        (wave)
  );

  // Gating by state silences the last toggle left in the generator at PLAY exit.
  assign buzzer = wave & (state == PLAY) & ~mute;
  assign busy   = (state != IDLE);
  assign done   = done_c;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed bench for buzzer_sched with a shortened timebase (TICK_DIV=10,
// HP=3/4/5/6, DUR=2/3/4/5, GAP_TICKS=1).
module tb_buzzer_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mute;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  int checks = 0;
  int errors = 0;

  localparam int GAP_CYC = 10;

  buzzer_sched #(
    .TICK_DIV (10), .GAP_TICKS (1),
    .HP0 (3), .HP1 (4), .HP2 (5), .HP3 (6),
    .DUR0 (2), .DUR1 (3), .DUR2 (4), .DUR3 (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse req for one cycle (or leave it held) and advance to PLAY cycle 0.
  task automatic start_req(input logic [3:0] mask, input bit hold);
    req = mask;
    step();
    if (!hold) req = 4'd0;
    check("busy_before_grant", busy, 1'b0);
    step();
  endtask

  // Checks PLAY cycles 0..n-1 (stopping early at stop_k); optionally pulses
  // extra request bits at cycle pulse_k. Buzzer model: (k / hp) % 2.
  task automatic play_check(input logic [1:0] id, input int hp, input int n, input bit muted,
                            input int pulse_k, input logic [3:0] pulse_mask, input int stop_k);
    for (int k = 0; k < n && k < stop_k; k++) begin
      check($sformatf("play%0d_busy_k%0d", id, k), busy, 1'b1);
      check($sformatf("play%0d_id_k%0d", id, k), active_id, id);
      check($sformatf("play%0d_buz_k%0d", id, k), buzzer, muted ? 1'b0 : 1'(((k / hp) % 2)));
      check($sformatf("play%0d_done_k%0d", id, k), done, (k == n - 1) ? 1'b1 : 1'b0);
      if (k == pulse_k) req = req | pulse_mask;
      if (k == pulse_k + 1) req = req & ~pulse_mask;
      step();
    end
  endtask

  task automatic gap_check(input logic [1:0] id);
    for (int k = 0; k < GAP_CYC; k++) begin
      check($sformatf("gap_busy_k%0d", k), busy, 1'b1);
      check($sformatf("gap_buz_k%0d", k), buzzer, 1'b0);
      check($sformatf("gap_done_k%0d", k), done, 1'b0);
      check($sformatf("gap_id_k%0d", k), active_id, id);
      step();
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_busy_k%0d", tag, k), busy, 1'b0);
      check($sformatf("%s_buz_k%0d", tag, k), buzzer, 1'b0);
      check($sformatf("%s_done_k%0d", tag, k), done, 1'b0);
      step();
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'd0;
    mute = 1'b0;
    #3;
    check("rst_buzzer", buzzer, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_id", active_id, 2'd0);
    check("rst_done", done, 1'b0);
    step();
    step();
    rst = 1'b0;
    idle_check("post_rst", 3);

    // Single pulse on source 0.
    start_req(4'b0001, 1'b0);
    play_check(2'd0, 3, 20, 1'b0, -5, 4'd0, 1000);
    gap_check(2'd0);
    idle_check("t1_end", 3);

    // Simultaneous sources 1 and 3: index order, back-to-back after gap.
    start_req(4'b1010, 1'b0);
    play_check(2'd1, 4, 30, 1'b0, -5, 4'd0, 1000);
    gap_check(2'd1);
    play_check(2'd3, 6, 50, 1'b0, -5, 4'd0, 1000);
    gap_check(2'd3);
    idle_check("t2_end", 3);

    // Source 0 arrives mid-tone of source 3: no preemption.
    start_req(4'b1000, 1'b0);
    play_check(2'd3, 6, 50, 1'b0, 10, 4'b0001, 1000);
    gap_check(2'd3);
    play_check(2'd0, 3, 20, 1'b0, -5, 4'd0, 1000);
    gap_check(2'd0);
    idle_check("t3_end", 3);

    // Source 2 held high for 200 cycles: exactly one tone.
    start_req(4'b0100, 1'b1);
    play_check(2'd2, 5, 40, 1'b0, -5, 4'd0, 1000);
    gap_check(2'd2);
    idle_check("t4_hold", 148);
    req = 4'd0;
    idle_check("t4_end", 5);

    // Muted playback keeps busy/done timing.
    mute = 1'b1;
    start_req(4'b0010, 1'b0);
    play_check(2'd1, 4, 30, 1'b1, -5, 4'd0, 1000);
    gap_check(2'd1);
    idle_check("t5_end", 3);
    mute = 1'b0;

    // Reset mid-PLAY of source 1 with source 2 pending.
    start_req(4'b0010, 1'b0);
    play_check(2'd1, 4, 30, 1'b0, 2, 4'b0100, 5);
    check("pre_rst_buzzer", buzzer, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_buzzer", buzzer, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_id", active_id, 2'd0);
    check("async_rst_done", done, 1'b0);
    step();
    step();
    rst = 1'b0;
    idle_check("t6_after", 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
